// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one stb/ack floating-point adder among NREQ requesters.
// Optional grant locking across back-to-back sums: define ADDER_ARB_LOCK_EN.
module adder_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATALENGTH = 32
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic [NREQ-1:0]            Req,
  input  logic [NREQ-1:0]            Lock,
  input  logic [NREQ*DATALENGTH-1:0] OpA,
  input  logic [NREQ*DATALENGTH-1:0] OpB,
  output logic [NREQ-1:0]            Gnt,
  output logic [NREQ-1:0]            Done,
  output logic [DATALENGTH-1:0]      Result,
  output logic                       Busy,
  output logic [DATALENGTH-1:0]      Add_a,
  output logic [DATALENGTH-1:0]      Add_b,
  output logic                       Add_a_stb,
  output logic                       Add_b_stb,
  output logic                       Add_z_ack,
  input  logic                       Add_a_ack,
  input  logic                       Add_b_ack,
  input  logic                       Add_z_stb,
  input  logic [DATALENGTH-1:0]      Add_z
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [2:0] {
    IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, WAIT_Z, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NREQ-1:0]         gnt_q, gnt_d;
  logic [NREQ-1:0]         done_q, done_d;
  logic [DATALENGTH-1:0]   result_q, result_d;
  logic                    busy_q, busy_d;
  logic [DATALENGTH-1:0]   add_a_q, add_a_d;
  logic [DATALENGTH-1:0]   add_b_q, add_b_d;
  logic                    a_stb_q, a_stb_d;
  logic                    b_stb_q, b_stb_d;
  logic                    z_ack_q, z_ack_d;

  logic [PTR_W-1:0]        sel_idx;
  logic                    sel_found;
  logic [PTR_W-1:0]        cand;

`ifndef ADDER_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^Lock;
`endif

  // Search upward from the requester after the last winner, wrapping at NREQ.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NREQ);
      if (!sel_found && Req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    a_stb_d  = a_stb_q;
    b_stb_d  = b_stb_q;
    z_ack_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d   = ONE_HOT0 << sel_idx;
          ptr_d   = sel_idx;
          add_a_d = OpA[sel_idx*DATALENGTH +: DATALENGTH];
          add_b_d = OpB[sel_idx*DATALENGTH +: DATALENGTH];
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (Add_a_ack) begin
          a_stb_d = 1'b1;
          state_d = WAIT_A;
        end
      end
      WAIT_A: begin
        if (!Add_a_ack) begin
          a_stb_d = 1'b0;
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        if (Add_b_ack) begin
          b_stb_d = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (!Add_b_ack) begin
          b_stb_d = 1'b0;
          state_d = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (Add_z_stb) begin
          result_d = Add_z;
          z_ack_d  = 1'b1;
          done_d   = ONE_HOT0 << ptr_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
`ifdef ADDER_ARB_LOCK_EN
        // Locked owner keeps the adder; Ptr stays put so others wait.
        if (Lock[ptr_q] && Req[ptr_q]) begin
          gnt_d   = gnt_q;
          add_a_d = OpA[ptr_q*DATALENGTH +: DATALENGTH];
          add_b_d = OpB[ptr_q*DATALENGTH +: DATALENGTH];
          state_d = SEND_A;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(NREQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      a_stb_q  <= 1'b0;
      b_stb_q  <= 1'b0;
      z_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      a_stb_q  <= a_stb_d;
      b_stb_q  <= b_stb_d;
      z_ack_q  <= z_ack_d;
    end
  end

  assign Gnt       = gnt_q;
  assign Done      = done_q;
  assign Result    = result_q;
  assign Busy      = busy_q;
  assign Add_a     = add_a_q;
  assign Add_b     = add_b_q;
  assign Add_a_stb = a_stb_q;
  assign Add_b_stb = b_stb_q;
  assign Add_z_ack = z_ack_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a table-driven stb/ack adder model.
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int DL   = 32;

  localparam logic [31:0] VA [8] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h40A00000,
                                     32'h3F000000, 32'h40E00000, 32'h40400000, 32'h41000000};
  localparam logic [31:0] VB [8] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40C00000,
                                     32'h3F800000, 32'h3F800000, 32'h40C00000, 32'h40800000};
  // Hand-computed sums: 3, 5, 5, 11, 1.5, 8, 9, 12
  localparam logic [31:0] VZ [8] = '{32'h40400000, 32'h40A00000, 32'h40A00000, 32'h41300000,
                                     32'h3FC00000, 32'h41000000, 32'h41100000, 32'h41400000};

  logic                 Clock, Reset_n;
  logic [NREQ-1:0]      Req, Lock, Gnt, Done;
  logic [NREQ*DL-1:0]   OpA, OpB;
  logic [DL-1:0]        Result, Add_a, Add_b, Add_z;
  logic                 Busy, Add_a_stb, Add_b_stb, Add_z_ack;
  logic                 Add_a_ack, Add_b_ack, Add_z_stb;

  int errors = 0;
  int checks = 0;

  logic [3:0]  exp_gnt[$];
  logic [3:0]  exp_done[$];
  logic [31:0] exp_res[$];
  logic [3:0]  prev_gnt;

  logic        stall_a, z_stall;
  logic        a_ack_r, b_ack_r, got_a, got_b;
  logic [31:0] a_cap, b_cap;

  adder_arbiter #(.NREQ(NREQ), .DATALENGTH(DL)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Lock(Lock), .OpA(OpA), .OpB(OpB),
    .Gnt(Gnt), .Done(Done), .Result(Result), .Busy(Busy), .Add_a(Add_a), .Add_b(Add_b),
    .Add_a_stb(Add_a_stb), .Add_b_stb(Add_b_stb), .Add_z_ack(Add_z_ack),
    .Add_a_ack(Add_a_ack), .Add_b_ack(Add_b_ack), .Add_z_stb(Add_z_stb), .Add_z(Add_z));

  always #5 Clock = ~Clock;

  function automatic logic [31:0] fadd_lut(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++)
      if (VA[i] == a && VB[i] == b) return VZ[i];
    return 32'hDEADBEEF;
  endfunction

  // Adder model: ack idles high, drops once it takes a strobe, returns when strobe drops.
  assign Add_a_ack = a_ack_r & ~stall_a;
  assign Add_b_ack = b_ack_r;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      a_ack_r <= 1'b1; b_ack_r <= 1'b1; got_a <= 1'b0; got_b <= 1'b0;
      a_cap <= '0; b_cap <= '0; Add_z_stb <= 1'b0; Add_z <= '0;
    end else begin
      if (Add_a_stb && Add_a_ack) begin
        a_cap <= Add_a; got_a <= 1'b1; a_ack_r <= 1'b0;
      end else if (!Add_a_stb && !a_ack_r) a_ack_r <= 1'b1;
      if (Add_b_stb && Add_b_ack) begin
        b_cap <= Add_b; got_b <= 1'b1; b_ack_r <= 1'b0;
      end else if (!Add_b_stb && !b_ack_r) b_ack_r <= 1'b1;
      if (got_a && got_b && !Add_z_stb && !z_stall) begin
        Add_z_stb <= 1'b1; Add_z <= fadd_lut(a_cap, b_cap);
        got_a <= 1'b0; got_b <= 1'b0;
      end else if (Add_z_stb && Add_z_ack) Add_z_stb <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: grant order on each new grant, result on each Done pulse.
  always @(negedge Clock) begin
    if (Reset_n) begin
      check("gnt_onehot", 32'($countones(Gnt) <= 1), 32'd1);
      if (Gnt != 0 && prev_gnt == 0) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(Gnt), 32'd0);
        else check("gnt_order", 32'(Gnt), 32'(exp_gnt.pop_front()));
      end
      if (Done != 0) begin
        if (exp_done.size() == 0) check("done_unexpected", 32'(Done), 32'd0);
        else begin
          check("done_bit", 32'(Done), 32'(exp_done.pop_front()));
          check("result", Result, exp_res.pop_front());
        end
      end
    end
    prev_gnt <= Gnt;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (Done != 0) return;
    end
    checks++; errors++;
    $display("FAIL wait_done: got timeout expected Done pulse");
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (Gnt != 0) return;
    end
    checks++; errors++;
    $display("FAIL wait_gnt: got timeout expected grant");
  endtask

  task automatic set_op(input int r, input int v);
    OpA[r*DL +: DL] = VA[v];
    OpB[r*DL +: DL] = VB[v];
  endtask

  task automatic expect_txn(input logic [3:0] g, input int v, input bit new_gnt);
    if (new_gnt) exp_gnt.push_back(g);
    exp_done.push_back(g);
    exp_res.push_back(VZ[v]);
  endtask

  initial begin
    Clock = 0; Reset_n = 0; Req = 0; Lock = 0; OpA = '0; OpB = '0;
    stall_a = 0; z_stall = 0; prev_gnt = 0;
    tick(2);
    check("rst_gnt", 32'(Gnt), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_strobes", 32'({Add_a_stb, Add_b_stb, Add_z_ack}), 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_add_a", Add_a, 32'd0);
    check("rst_add_b", Add_b, 32'd0);
    Reset_n = 1;
    tick(1);

    // Single request; operand change and Req drop after grant must not matter
    set_op(0, 0);
    expect_txn(4'b0001, 0, 1);
    Req = 4'b0001;
    tick(1);
    check("req_to_gnt", 32'(Gnt), 32'h1);
    Req = 0;
    OpA[31:0] = 32'h12345678;
    wait_done();
    tick(1);
    check("gnt_clear", 32'(Gnt), 32'd0);
    check("busy_idle", 32'(Busy), 32'd0);
    check("result_held", Result, VZ[0]);

    // All four requesting from reset: 0,1,2,3,0
    Reset_n = 0; tick(1); Reset_n = 1; tick(1);
    set_op(0, 1); set_op(1, 2); set_op(2, 3); set_op(3, 4);
    expect_txn(4'b0001, 1, 1); expect_txn(4'b0010, 2, 1); expect_txn(4'b0100, 3, 1);
    expect_txn(4'b1000, 4, 1); expect_txn(4'b0001, 1, 1);
    Req = 4'b1111;
    repeat (5) wait_done();
    Req = 0;
    tick(2);

    // After requester 1 is served, 0111 must go to 2
    set_op(0, 0); set_op(1, 5); set_op(2, 6);
    expect_txn(4'b0010, 5, 1); expect_txn(4'b0100, 6, 1);
    Req = 4'b0010;
    wait_done();
    Req = 4'b0111;
    wait_done();
    Req = 0;
    tick(2);

    // A-channel ack held low for 10 cycles
    set_op(3, 7);
    stall_a = 1;
    expect_txn(4'b1000, 7, 1);
    Req = 4'b1000;
    wait_gnt();
    Req = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_a_stb", 32'(Add_a_stb), 32'd0);
      check("stall_busy", 32'(Busy), 32'd1);
    end
    stall_a = 0;
    wait_done();
    tick(2);

    // Reset while waiting on Z
    set_op(0, 0);
    z_stall = 1;
    exp_gnt.push_back(4'b0001);
    Req = 4'b0001;
    wait_gnt();
    Req = 0;
    tick(12);
    check("waitz_busy", 32'(Busy), 32'd1);
    Reset_n = 0;
    tick(1);
    check("midrst_gnt", 32'(Gnt), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_strobes", 32'({Add_a_stb, Add_b_stb, Add_z_ack}), 32'd0);
    check("midrst_result", Result, 32'd0);
    Reset_n = 1;
    z_stall = 0;
    tick(1);
    set_op(1, 2);
    expect_txn(4'b0010, 2, 1);
    Req = 4'b0010;
    wait_done();
    Req = 0;
    tick(2);

    // Lock: requester 0 holds lock for three sums while 1 also requests
    set_op(0, 0); set_op(1, 4);
`ifdef ADDER_ARB_LOCK_EN
    expect_txn(4'b0001, 0, 1); expect_txn(4'b0001, 0, 0); expect_txn(4'b0001, 0, 0);
    expect_txn(4'b0010, 4, 1);
    Req = 4'b0011; Lock = 4'b0001;
    repeat (3) wait_done();
    Req = 4'b0010; Lock = 0;
    wait_done();
    Req = 0;
`else
    expect_txn(4'b0001, 0, 1); expect_txn(4'b0010, 4, 1); expect_txn(4'b0001, 0, 1);
    Req = 4'b0011; Lock = 4'b0001;
    repeat (3) wait_done();
    Req = 0; Lock = 0;
`endif
    tick(3);
    check("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
